fifo_ctrl: RTL and testbench
============================

# fifo_ctrl

Queue controller that turns the 32×32 register file into a circular FIFO, sitting directly upstream of the register file. It owns head/tail pointers and occupancy, drives the register file write port and one read port, and presents a registered dequeue result with full/empty/status flags. Register-file entry 0 is hardwired to zero and unwritable, so queue slots map to addresses 1..DEPTH.

## Interface
- DEPTH, 8, queue capacity in entries; legal 2..31
- DATA_W, 32, data width; must equal the register-file data width
- clk  in  1  single clock, all state updates on rising edge
- rstn  in  1  reset, synchronous, active-low
- enq  in  1  enqueue request (pulse, or level with FIFO_CTRL_EDGE_EN)
- deq  in  1  dequeue request (same qualification as enq)
- din  in  DATA_W  data to enqueue
- dout  out  DATA_W  last dequeued value, registered
- dout_valid  out  1  one-cycle pulse when dout updates
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- count  out  5  current occupancy 0..DEPTH
- ovf  out  1  one-cycle pulse: enqueue rejected because full with no concurrent accepted dequeue
- udf  out  1  one-cycle pulse: dequeue rejected because empty
- rf_we  out  1  register-file write enable
- rf_wa  out  5  register-file write address (= tail)
- rf_wd  out  DATA_W  register-file write data (= din)
- rf_ra  out  5  register-file read address (= head), to ra1
- rf_rd  in  DATA_W  register-file read data, from rd1

## Operation
- Pointers hd, tl in 1..DEPTH; advance DEPTH → 1 (never 0). Occupancy count 0..DEPTH.
- State (registered): S_EMPTY, S_PART, S_FULL; empty/full decoded from state. Transitions: EMPTY→PART on accepted enq; PART→FULL when count reaches DEPTH; PART→EMPTY when count reaches 0; FULL→PART on dequeue-only.
- Accepted enq (do_enq): enq && (!full || do_deq). rf_we = do_enq && rstn, combinational, same cycle; tl advances.
- Accepted deq (do_deq): deq && !empty. rf_ra = hd always; dout <= rf_rd; hd advances.
- Simultaneous enq+deq:
  - empty: enq accepted, deq rejected (udf=1); count +1.
  - partial: both accepted; count unchanged.
  - full: both accepted; tl == hd, and the read returns the old head because the register-file write lands at the edge; count unchanged.
- Rejected requests change no state except the ovf/udf pulse.
- Reset (rstn low at an edge): hd=tl=1, count=0, state=S_EMPTY, dout=0, dout_valid=0, ovf=udf=0; rf_we forced 0 while rstn low. Register-file contents are not cleared. Reset mid-operation discards queued data logically.

## Timing
- Enqueue in cycle n: write committed at edge ending n; count/full/empty updated from cycle n+1.
- Dequeue in cycle n: dout and dout_valid=1 in cycle n+1; dout_valid low again in n+2 unless another dequeue occurred.
- Back-to-back requests accepted every cycle; throughput one enq and one deq per cycle.
- Data enqueued in cycle n is dequeueable from cycle n+1 (write-then-read through the register file, no bypass needed).
- ovf/udf asserted in cycle n+1 for a rejected request in cycle n.

## Configuration
- FIFO_CTRL_EDGE_EN defined: enq/deq are levels (e.g. debounced buttons); internal rising-edge detectors (previous-value register, reset to 0) produce one qualified request per 0→1 transition, in the same cycle the level first reads high; a held level acts once.
- Undefined: enq/deq used directly as requests; held high means one request per cycle.

## Structure
- Package fifo_ctrl_pkg: state enum (S_EMPTY, S_PART, S_FULL), RF_ADDR_W = 5, FIRST_SLOT = 1, pointer-increment-with-wrap function.
- Sub-module edge_pulse (one bit, clk/rstn, level in, pulse out), instantiated twice only under FIFO_CTRL_EDGE_EN.

## Test plan
- Reset, then enqueue 0x11, 0x22, 0x33 on consecutive cycles -> rf_wa = 1,2,3 with rf_we=1; count=3; empty=0.
- Dequeue three times -> dout = 0x11, 0x22, 0x33 in successive cycles, dout_valid high each; empty=1 after.
- Fill DEPTH=8 entries, enqueue again -> ovf pulse, count stays 8, tl unchanged; then enq+deq together -> dout = first entry, slot 1 rewritten, count 8.
- From empty, enq+deq together with din=0xAB -> udf pulse, count=1; next deq -> dout=0xAB.
- Wrap: 20 alternating enq/deq with incrementing data -> addresses cycle 1..8 then 1, never 0; data order preserved.
- Assert rstn low with count=5 -> next cycle count=0, empty=1, dout=0, rf_we=0 during reset.

Source files
------------

// File: rtl/fifo_ctrl_pkg.sv
// Shared types and helpers for the register-file backed FIFO controller.
package fifo_ctrl_pkg;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_PART,
    S_FULL
  } state_e;

  localparam int RF_ADDR_W = 5;

  // Register-file entry 0 is hardwired to zero, so queue slots start at 1.
  localparam logic [RF_ADDR_W-1:0] FIRST_SLOT = 5'd1;

  // Advance a slot pointer, wrapping from the last slot back to FIRST_SLOT.
  function automatic logic [RF_ADDR_W-1:0] ptr_inc(input logic [RF_ADDR_W-1:0] ptr,
                                                   input logic [RF_ADDR_W-1:0] last);
    return (ptr == last) ? FIRST_SLOT : ptr + 5'd1;
  endfunction

endpackage

// File: rtl/fifo_ctrl_edge_pulse.sv
// Rising-edge detector: one-cycle pulse in the same cycle a level first reads high.
module edge_pulse (
  input  logic clk,
  input  logic rstn,
  input  logic level_i,
  output logic pulse_o
);

  logic prev_q;

  // Remember last cycle's level so a held level only fires once.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) prev_q <= 1'b0;
    else       prev_q <= level_i;
  end

  assign pulse_o = level_i & ~prev_q;

endmodule

// File: rtl/fifo_ctrl.sv
// Circular FIFO controller over a 32x32 register file (slots 1..DEPTH).
// Optional build macro FIFO_CTRL_EDGE_EN: enq/deq are levels, qualified by
// rising-edge detectors; undefined, they are used directly as per-cycle requests.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 enq,
  input  logic                 deq,
  input  logic [DATA_W-1:0]    din,
  output logic [DATA_W-1:0]    dout,
  output logic                 dout_valid,
  output logic                 full,
  output logic                 empty,
  output logic [4:0]           count,
  output logic                 ovf,
  output logic                 udf,
  output logic                 rf_we,
  output logic [RF_ADDR_W-1:0] rf_wa,
  output logic [DATA_W-1:0]    rf_wd,
  output logic [RF_ADDR_W-1:0] rf_ra,
  input  logic [DATA_W-1:0]    rf_rd
);

  localparam logic [RF_ADDR_W-1:0] LAST_SLOT = RF_ADDR_W'(DEPTH);

  state_e                 state_q;
  logic [RF_ADDR_W-1:0]   hd_q, tl_q;
  logic [4:0]             count_q, count_d;
  logic [DATA_W-1:0]      dout_q;
  logic                   dout_valid_q, ovf_q, udf_q;
  logic                   enq_req, deq_req, do_enq, do_deq;

`ifdef FIFO_CTRL_EDGE_EN
  edge_pulse u_enq_edge (.clk(clk), .rstn(rstn), .level_i(enq), .pulse_o(enq_req));
  edge_pulse u_deq_edge (.clk(clk), .rstn(rstn), .level_i(deq), .pulse_o(deq_req));
`else
  assign enq_req = enq;
  assign deq_req = deq;
`endif

  assign full  = (state_q == S_FULL);
  assign empty = (state_q == S_EMPTY);

  // A dequeue frees a slot in the same cycle, so a full FIFO still accepts enq+deq.
  assign do_deq = deq_req & ~empty;
  assign do_enq = enq_req & (~full | do_deq);

  // Occupancy after this cycle's accepted requests.
  // NOTE: count_d is assigned on every path first, so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (do_enq && !do_deq)      count_d = count_q + 5'd1;
    else if (do_deq && !do_enq) count_d = count_q - 5'd1;
  end

  // Register-file ports: the write lands at the edge, so a same-cycle read of the
  // same slot (full, enq+deq) still returns the old head.
  // NOTE: the register file itself is never cleared; reset only rewinds pointers.
  assign rf_we = do_enq & rstn;
  assign rf_wa = tl_q;
  assign rf_wd = din;
  assign rf_ra = hd_q;

  // Pointers, occupancy, occupancy state and registered result/status pulses.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= S_EMPTY;
      hd_q         <= FIRST_SLOT;
      tl_q         <= FIRST_SLOT;
      count_q      <= 5'd0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
      udf_q        <= 1'b0;
    end else begin
      if (do_enq) tl_q <= ptr_inc(tl_q, LAST_SLOT);
      if (do_deq) begin
        hd_q   <= ptr_inc(hd_q, LAST_SLOT);
        dout_q <= rf_rd;
      end
      count_q      <= count_d;
      dout_valid_q <= do_deq;
      ovf_q        <= enq_req & full & ~do_deq;
      udf_q        <= deq_req & empty;
      case (state_q)
        S_EMPTY: if (do_enq)                 state_q <= (count_d == LAST_SLOT) ? S_FULL : S_PART;
        S_PART:  if (count_d == LAST_SLOT)   state_q <= S_FULL;
                 else if (count_d == 5'd0)   state_q <= S_EMPTY;
        S_FULL:  if (do_deq && !do_enq)      state_q <= S_PART;
        default:                             state_q <= S_EMPTY;
      endcase
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign count      = count_q;
  assign ovf        = ovf_q;
  assign udf        = udf_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl (default build) with a behavioral register file.
module tb_fifo_ctrl;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 32;

  logic              clk, rstn, enq, deq;
  logic [DATA_W-1:0] din, dout, rf_wd, rf_rd;
  logic              dout_valid, full, empty, ovf, udf, rf_we;
  logic [4:0]        count, rf_wa, rf_ra;

  fifo_ctrl #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .rstn(rstn), .enq(enq), .deq(deq), .din(din),
    .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty),
    .count(count), .ovf(ovf), .udf(udf), .rf_we(rf_we), .rf_wa(rf_wa),
    .rf_wd(rf_wd), .rf_ra(rf_ra), .rf_rd(rf_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: entry 0 reads zero and ignores writes.
  logic [DATA_W-1:0] rf [32];
  initial for (int i = 0; i < 32; i++) rf[i] = '0;
  always @(posedge clk) if (rf_we && rf_wa != 5'd0) rf[rf_wa] <= rf_wd;
  assign rf_rd = (rf_ra == 5'd0) ? '0 : rf[rf_ra];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state and scoreboard queues.
  int                m_count;
  logic [4:0]        m_hd, m_tl;
  logic [DATA_W-1:0] stored_q [$];
  logic [DATA_W-1:0] exp_q [$];

  function automatic logic [4:0] nxt(input logic [4:0] p);
    return (p == 5'(DEPTH)) ? 5'd1 : p + 5'd1;
  endfunction

  // One clock cycle of stimulus with checks before and after the edge.
  task automatic step(input logic e, input logic d, input logic [DATA_W-1:0] data);
    logic acc_enq, acc_deq, m_full, m_empty;
    @(negedge clk);
    enq = e; deq = d; din = data;
    #1;
    m_full  = (m_count == DEPTH);
    m_empty = (m_count == 0);
    acc_deq = d && !m_empty;
    acc_enq = e && (!m_full || acc_deq);
    check("rf_we", {31'd0, rf_we}, {31'd0, acc_enq});
    if (acc_enq) begin
      check("rf_wa", {27'd0, rf_wa}, {27'd0, m_tl});
      check("rf_wd", rf_wd, data);
    end
    check("rf_ra", {27'd0, rf_ra}, {27'd0, m_hd});
    @(posedge clk);
    #1;
    if (acc_deq) begin
      if (stored_q.size() > 0) exp_q.push_back(stored_q.pop_front());
      m_hd = nxt(m_hd);
    end
    if (acc_enq) begin
      stored_q.push_back(data);
      m_tl = nxt(m_tl);
    end
    m_count = m_count + (acc_enq ? 1 : 0) - (acc_deq ? 1 : 0);
    check("count", {27'd0, count}, 32'(m_count));
    check("empty", {31'd0, empty}, {31'd0, m_count == 0});
    check("full", {31'd0, full}, {31'd0, m_count == DEPTH});
    check("ovf", {31'd0, ovf}, {31'd0, e && m_full && !acc_deq});
    check("udf", {31'd0, udf}, {31'd0, d && m_empty});
    check("dout_valid", {31'd0, dout_valid}, {31'd0, acc_deq});
    if (dout_valid) begin
      if (exp_q.size() == 0) check("dout_unexpected", 32'd1, 32'd0);
      else check("dout", dout, exp_q.pop_front());
    end
  endtask

  // Hold reset for one edge with an enqueue pending; rf_we must stay low.
  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0; enq = 1'b1; deq = 1'b0; din = 32'hDEAD_BEEF;
    #1;
    check("rf_we_in_reset", {31'd0, rf_we}, 32'd0);
    @(posedge clk);
    #1;
    m_count = 0; m_hd = 5'd1; m_tl = 5'd1;
    stored_q.delete(); exp_q.delete();
    check("rst_count", {27'd0, count}, 32'd0);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_dout", dout, 32'd0);
    check("rst_dout_valid", {31'd0, dout_valid}, 32'd0);
    check("rst_ovf_udf", {30'd0, ovf, udf}, 32'd0);
    @(negedge clk);
    rstn = 1'b1; enq = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; enq = 1'b0; deq = 1'b0; din = '0;
    m_count = 0; m_hd = 5'd1; m_tl = 5'd1;
    do_reset();

    // Three enqueues, then three dequeues.
    step(1, 0, 32'h11);
    step(1, 0, 32'h22);
    step(1, 0, 32'h33);
    step(0, 1, '0);
    step(0, 1, '0);
    step(0, 1, '0);
    step(0, 0, '0);

    // Fill from reset, overflow, then enq+deq while full rewrites slot 1.
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1, 0, 32'h100 + 32'(i));
    step(1, 0, 32'hBAD);
    step(1, 1, 32'h99);
    check("slot1_rewritten", rf[1], 32'h99);
    for (int i = 0; i < DEPTH; i++) step(0, 1, '0);
    step(0, 1, '0);

    // From empty: enq+deq together -> deq rejected, enq accepted.
    step(1, 1, 32'hAB);
    step(0, 1, '0);

    // Wrap with alternating enq/deq and incrementing data.
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 32'h200 + 32'(i));
      step(0, 1, '0);
    end

    // Mixed random traffic.
    for (int i = 0; i < 60; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);

    // Reset mid-operation with five queued entries.
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 0, 32'h300 + 32'(i));
    do_reset();
    step(0, 1, '0);
    step(1, 0, 32'h44);
    step(0, 1, '0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
